reg_writeback: RTL and testbench
================================

# reg_writeback

Write-back stage that drives the register-file write port (`regWrite`, `writeReg`, `writeData`) from results handed over by the memory stage. It holds one in-flight instruction. ALU results commit one cycle after acceptance. Loads wait for memory read data, then commit the aligned and sign/zero-extended value. It sits between the MEM stage and the register file, and its registered write-port outputs also serve as the WB forwarding source.

## Interface
- `DATA_W`, 32, data width; only 32 is supported
- `ADDR_W`, 5, register index width

- `clk` in 1: clock; everything samples on the rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: MEM stage presents an instruction
- `in_ready` out 1: WB can accept; transfer occurs when `in_valid & in_ready` at a rising edge
- `in_reg_write` in 1: instruction writes a register
- `in_mem_to_reg` in 1: result comes from memory (load); otherwise from `in_alu_result`
- `in_load_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word
- `in_load_unsigned` in 1: zero-extend (1) or sign-extend (0) byte/half loads
- `in_byte_off` in 2: low address bits of the load
- `in_write_reg` in ADDR_W: destination register
- `in_alu_result` in DATA_W: ALU result
- `mem_rdata_valid` in 1: load data valid this cycle
- `mem_rdata` in DATA_W: raw word from data memory
- `regWrite` out 1: register-file write enable (registered)
- `writeReg` out ADDR_W: register-file write address (registered)
- `writeData` out DATA_W: register-file write data (registered)
- `wb_done` out 1: one-cycle pulse when an instruction retires, written or not

## Operation
- States:
  - IDLE: nothing held.
  - WAIT_LOAD: load accepted, data not yet returned.
  - COMMIT: outputs are presenting a retirement.
- `in_ready` = (state != WAIT_LOAD). It is combinational from state, so it is 1 in IDLE and COMMIT, 0 in WAIT_LOAD.
- Accept of a non-load in IDLE or COMMIT → COMMIT next cycle.
  - `writeData` = `in_alu_result`, `writeReg` = `in_write_reg`.
  - `regWrite` = `in_reg_write & (in_write_reg != 0)`.
- Accept of a load (`in_mem_to_reg`=1) → WAIT_LOAD.
  - Capture size, unsigned flag, offset, destination register and write enable.
  - `regWrite`/`wb_done` are 0 in WAIT_LOAD.
- WAIT_LOAD with `mem_rdata_valid`=1 → COMMIT with aligned data.
  - Byte: lane `mem_rdata[8*off+7 : 8*off]`.
  - Half: `off[1]` selects upper (1) or lower (0) halfword; `off[0]` is ignored.
  - Word: offset ignored.
  - Extension is to 32 bits, sign or zero per the captured flag.
- COMMIT with no new accept → IDLE.
  - `regWrite`, `wb_done` return to 0.
  - `writeReg`/`writeData` hold their last values.
- `mem_rdata_valid` is ignored outside WAIT_LOAD.
- Writes to register 0 never assert `regWrite`; `wb_done` still pulses.

## Timing
- Reset: on a rising edge with `rst`=1:
  - state → IDLE.
  - `regWrite`=0, `writeReg`=0, `writeData`=0, `wb_done`=0.
  - Any held load is dropped with no write.
  - Inputs are not accepted on that edge.
- ALU latency: accepted at edge N → `regWrite`/`wb_done` high for the cycle following edge N.
  - Back-to-back accepts give one commit per cycle with `regWrite` continuously high.
- Load latency: accepted at edge N; `mem_rdata_valid` sampled high at edge M (M ≥ N+1) → commit in the cycle following edge M. Minimum is 2 cycles from acceptance.
- `mem_rdata_valid` at edge N itself (the accept edge) is ignored.
- Reset while in WAIT_LOAD: the next `mem_rdata_valid` produces no write.
- The register file captures `regWrite`/`writeReg`/`writeData` on the edge ending the COMMIT cycle.

## Test plan
- ALU write:
  - Stimulus: reset, then accept `in_reg_write`=1, `in_write_reg`=7, `in_alu_result`=0x1234_5678.
  - Required: next cycle `regWrite`=1, `writeReg`=7, `writeData`=0x1234_5678, `wb_done`=1; the cycle after, `regWrite`=0.
- Back-to-back ALU writes:
  - Stimulus: three consecutive accepts to r1, r2, r3.
  - Required: `in_ready` stays 1; three consecutive commit cycles in order.
- Signed byte load:
  - Stimulus: `in_load_size`=00, `in_load_unsigned`=0, `in_byte_off`=2, dest r4; `mem_rdata`=0x00_80_00_00 valid 3 cycles later.
  - Required: `in_ready`=0 while waiting; then `writeData`=0xFFFF_FF80, `regWrite`=1.
- Unsigned half load:
  - Stimulus: `in_load_size`=01, `in_load_unsigned`=1, `in_byte_off`=2, `mem_rdata`=0xBEEF_0000.
  - Required: `writeData`=0x0000_BEEF.
- Write to r0 / non-writing instruction:
  - Stimulus: accept with `in_write_reg`=0, `in_reg_write`=1; separately `in_reg_write`=0, dest 5.
  - Required: `regWrite` stays 0 in both cases; `wb_done` pulses once for each.
- Reset during WAIT_LOAD:
  - Stimulus: accept a load, assert `rst` one cycle, then pulse `mem_rdata_valid`.
  - Required: no `regWrite`, no `wb_done`; all outputs 0; `in_ready`=1 after reset.

Source files
------------

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Write-back stage between MEM and the register file. Holds one in-flight
// instruction. ALU results commit the cycle after acceptance; loads wait in
// WAIT_LOAD for mem_rdata_valid, then commit the lane-aligned, sign- or
// zero-extended value. The registered write port also acts as the WB
// forwarding source.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  MEM -> WB handshake (in_ready low only in WAIT_LOAD)
//   in_reg_write       instruction writes a register
//   in_mem_to_reg      result comes from memory (load)
//   in_load_size       00 byte, 01 half, 10/11 word
//   in_load_unsigned   zero-extend (1) / sign-extend (0) sub-word loads
//   in_byte_off        low address bits of the load
//   in_write_reg       destination register
//   in_alu_result      ALU result
//   mem_rdata_valid    load data valid this cycle
//   mem_rdata          raw word from data memory
//   regWrite           register-file write enable (registered)
//   writeReg           register-file write address (registered)
//   writeData          register-file write data (registered)
//   wb_done            one-cycle pulse per retirement, written or not
// ---------------------------------------------------------------------------
module reg_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_unsigned,
    input  logic [1:0]        in_byte_off,
    input  logic [ADDR_W-1:0] in_write_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              wb_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    state_t              state_q;
    logic                regWrite_q;
    logic [ADDR_W-1:0]   writeReg_q;
    logic [DATA_W-1:0]   writeData_q;
    logic                wb_done_q;

    // Load context captured at acceptance
    logic [1:0]          ld_size_q;
    logic                ld_uns_q;
    logic [1:0]          ld_off_q;
    logic [ADDR_W-1:0]   ld_reg_q;
    logic                ld_we_q;

    logic                accept;
    logic [DATA_W-1:0]   load_data_d;

    // Select the addressed byte/half lane and extend it to the full width.
    function automatic logic [DATA_W-1:0] load_align(
        input logic [DATA_W-1:0] rdata,
        input logic [1:0]        size,
        input logic              uns,
        input logic [1:0]        off
    );
        logic [DATA_W-1:0] shifted;
        logic [7:0]        b;
        logic [15:0]       h;
        logic              bsign;
        logic              hsign;
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        bsign   = b[7] & ~uns;
        hsign   = h[15] & ~uns;
        case (size)
            2'b00:   load_align = {{(DATA_W-8){bsign}}, b};
            2'b01:   load_align = {{(DATA_W-16){hsign}}, h};
            default: load_align = rdata;
        endcase
    endfunction

    assign in_ready    = (state_q != WAIT_LOAD);
    assign accept      = in_valid & in_ready;
    assign load_data_d = load_align(mem_rdata, ld_size_q, ld_uns_q, ld_off_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            wb_done_q   <= 1'b0;
            ld_size_q   <= 2'b00;
            ld_uns_q    <= 1'b0;
            ld_off_q    <= 2'b00;
            ld_reg_q    <= '0;
            ld_we_q     <= 1'b0;
        end else begin
            // Retirement strobes are single-cycle unless re-armed below
            regWrite_q <= 1'b0;
            wb_done_q  <= 1'b0;
            case (state_q)
                WAIT_LOAD: begin
                    if (mem_rdata_valid) begin
                        state_q     <= COMMIT;
                        regWrite_q  <= ld_we_q;
                        writeReg_q  <= ld_reg_q;
                        writeData_q <= load_data_d;
                        wb_done_q   <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and COMMIT both accept; a COMMIT without a new
                    // accept falls back to IDLE, holding writeReg/writeData.
                    if (accept) begin
                        if (in_mem_to_reg) begin
                            state_q   <= WAIT_LOAD;
                            ld_size_q <= in_load_size;
                            ld_uns_q  <= in_load_unsigned;
                            ld_off_q  <= in_byte_off;
                            ld_reg_q  <= in_write_reg;
                            ld_we_q   <= in_reg_write & (in_write_reg != '0);
                        end else begin
                            state_q     <= COMMIT;
                            regWrite_q  <= in_reg_write & (in_write_reg != '0);
                            writeReg_q  <= in_write_reg;
                            writeData_q <= in_alu_result;
                            wb_done_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;
    assign wb_done   = wb_done_q;

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [1:0]  in_byte_off;
    logic [4:0]  in_write_reg;
    logic [31:0] in_alu_result;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        wb_done;

    int n_chk  = 0;
    int n_fail = 0;

    reg_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_reg_write     (in_reg_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_byte_off      (in_byte_off),
        .in_write_reg     (in_write_reg),
        .in_alu_result    (in_alu_result),
        .mem_rdata_valid  (mem_rdata_valid),
        .mem_rdata        (mem_rdata),
        .regWrite         (regWrite),
        .writeReg         (writeReg),
        .writeData        (writeData),
        .wb_done          (wb_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_accept(input logic we, input logic [4:0] rd, input logic [31:0] res);
        in_valid      = 1'b1;
        in_mem_to_reg = 1'b0;
        in_reg_write  = we;
        in_write_reg  = rd;
        in_alu_result = res;
    endtask

    // Accept a load, wait so that valid data is sampled lat edges after the
    // accept edge, then check the committed value. A bogus valid is driven
    // on the accept edge itself, which must be ignored.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [1:0] off, input logic [4:0] rd,
                           input logic [31:0] rdata, input int lat,
                           input logic [31:0] exp);
        in_valid         = 1'b1;
        in_mem_to_reg    = 1'b1;
        in_reg_write     = 1'b1;
        in_load_size     = sz;
        in_load_unsigned = uns;
        in_byte_off      = off;
        in_write_reg     = rd;
        mem_rdata_valid  = 1'b1;
        mem_rdata        = ~rdata;
        step();
        in_valid        = 1'b0;
        mem_rdata_valid = 1'b0;
        for (int k = 1; k < lat; k++) begin
            check_val({tag, "_wait_ready"}, {31'd0, in_ready}, 32'd0);
            check_val({tag, "_wait_we"}, {31'd0, regWrite}, 32'd0);
            check_val({tag, "_wait_done"}, {31'd0, wb_done}, 32'd0);
            step();
        end
        check_val({tag, "_ready_before"}, {31'd0, in_ready}, 32'd0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = rdata;
        step();
        mem_rdata_valid = 1'b0;
        check_val({tag, "_data"}, writeData, exp);
        check_val({tag, "_we"}, {31'd0, regWrite}, 32'd1);
        check_val({tag, "_reg"}, {27'd0, writeReg}, {27'd0, rd});
        check_val({tag, "_done"}, {31'd0, wb_done}, 32'd1);
        check_val({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
        step();
        check_val({tag, "_we_drop"}, {31'd0, regWrite}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_load_size = 2'b00; in_load_unsigned = 1'b0; in_byte_off = 2'b00;
        in_write_reg = 5'd0; in_alu_result = 32'd0; mem_rdata_valid = 1'b0;
        mem_rdata = 32'd0;
        step();
        step();
        rst = 1'b0;
        check_val("rst_we", {31'd0, regWrite}, 32'd0);
        check_val("rst_reg", {27'd0, writeReg}, 32'd0);
        check_val("rst_data", writeData, 32'd0);
        check_val("rst_done", {31'd0, wb_done}, 32'd0);
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);

        // Single ALU write
        alu_accept(1'b1, 5'd7, 32'h1234_5678);
        step();
        in_valid = 1'b0;
        check_val("alu_we", {31'd0, regWrite}, 32'd1);
        check_val("alu_reg", {27'd0, writeReg}, 32'd7);
        check_val("alu_data", writeData, 32'h1234_5678);
        check_val("alu_done", {31'd0, wb_done}, 32'd1);
        step();
        check_val("alu_we_drop", {31'd0, regWrite}, 32'd0);
        check_val("alu_done_drop", {31'd0, wb_done}, 32'd0);
        check_val("alu_data_hold", writeData, 32'h1234_5678);
        check_val("alu_reg_hold", {27'd0, writeReg}, 32'd7);

        // Back-to-back ALU writes r1, r2, r3
        for (int i = 1; i <= 3; i++) begin
            alu_accept(1'b1, 5'(i), 32'h1111_0000 + 32'(i));
            check_val("b2b_ready", {31'd0, in_ready}, 32'd1);
            step();
            check_val("b2b_we", {31'd0, regWrite}, 32'd1);
            check_val("b2b_reg", {27'd0, writeReg}, 32'(i));
            check_val("b2b_data", writeData, 32'h1111_0000 + 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_val("b2b_end_we", {31'd0, regWrite}, 32'd0);

        // Loads: size, unsigned, offset, dest, raw word, latency, expected
        do_load("lb_s_off2", 2'b00, 1'b0, 2'd2, 5'd4,  32'h0080_0000, 3, 32'hFFFF_FF80);
        do_load("lhu_off2",  2'b01, 1'b1, 2'd2, 5'd9,  32'hBEEF_0000, 1, 32'h0000_BEEF);
        do_load("lbu_off3",  2'b00, 1'b1, 2'd3, 5'd10, 32'hA512_3456, 2, 32'h0000_00A5);
        do_load("lb_s_off1", 2'b00, 1'b0, 2'd1, 5'd11, 32'hFFFF_7FFF, 1, 32'h0000_007F);
        do_load("lh_s_off1", 2'b01, 1'b0, 2'd1, 5'd12, 32'h1234_8001, 1, 32'hFFFF_8001);
        do_load("lw_sz3",    2'b11, 1'b0, 2'd1, 5'd13, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);

        // Write to r0: retires without a write
        alu_accept(1'b1, 5'd0, 32'hCAFE_0000);
        step();
        in_valid = 1'b0;
        check_val("r0_we", {31'd0, regWrite}, 32'd0);
        check_val("r0_done", {31'd0, wb_done}, 32'd1);
        step();
        check_val("r0_done_drop", {31'd0, wb_done}, 32'd0);

        // Non-writing instruction
        alu_accept(1'b0, 5'd5, 32'h0000_5555);
        step();
        in_valid = 1'b0;
        check_val("nowr_we", {31'd0, regWrite}, 32'd0);
        check_val("nowr_done", {31'd0, wb_done}, 32'd1);
        step();
        check_val("nowr_done_drop", {31'd0, wb_done}, 32'd0);

        // Reset while waiting for load data
        in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1;
        in_load_size = 2'b10; in_write_reg = 5'd6;
        step();
        in_valid = 1'b0;
        check_val("rstld_wait_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rstld_ready", {31'd0, in_ready}, 32'd1);
        check_val("rstld_data", writeData, 32'd0);
        check_val("rstld_reg", {27'd0, writeReg}, 32'd0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hFFFF_FFFF;
        step();
        mem_rdata_valid = 1'b0;
        check_val("rstld_we", {31'd0, regWrite}, 32'd0);
        check_val("rstld_done", {31'd0, wb_done}, 32'd0);
        check_val("rstld_data_after", writeData, 32'd0);
        check_val("rstld_ready_after", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
